// File: rtl/sort_pkg.sv
// Shared types and constants for the sort_arbiter block and its round-robin picker.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        GRANT_S = 2'd1,
        DROP_S  = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 16;

    // Adds up to 16 discards in one cycle and clamps at all-ones.
    function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] cnt,
                                                      input logic [4:0]            inc);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_W - 4){1'b0}}, inc};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest distance above ptr_i (wrapping) wins.
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IW'((int'(ptr_i) + k) % NUM_SRC);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// Packet-granular round-robin arbiter sharing one sorting engine between NUM_SRC
// Avalon-ST requesters, with length truncation and stray-beat discard counting.
module sort_arbiter
    import sort_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic [NUM_SRC-1:0][DWIDTH-1:0]   snk_data_i,
    input  logic [NUM_SRC-1:0]               snk_startofpacket_i,
    input  logic [NUM_SRC-1:0]               snk_endofpacket_i,
    input  logic [NUM_SRC-1:0]               snk_valid_i,
    output logic [NUM_SRC-1:0]               snk_ready_o,
    output logic [DWIDTH-1:0]                src_data_o,
    output logic                             src_startofpacket_o,
    output logic                             src_endofpacket_o,
    output logic                             src_valid_o,
    input  logic                             src_ready_i,
    output logic [$clog2(NUM_SRC)-1:0]       grant_id_o,
    output logic                             busy_o,
    output logic [DROP_CNT_W-1:0]            drop_cnt_o
);

    localparam int              IW        = $clog2(NUM_SRC);
    localparam int              BW        = $clog2(MAX_PKT_LEN + 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(MAX_PKT_LEN - 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   src_valid_q, src_valid_d;
    logic                   src_sop_q, src_sop_d;
    logic                   src_eop_q, src_eop_d;
    logic [DWIDTH-1:0]      src_data_q, src_data_d;

    logic [NUM_SRC-1:0]     req;
    logic [NUM_SRC-1:0]     pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   busy;
    logic                   out_free;
    logic [4:0]             drop_inc;

    assign req  = snk_valid_i & snk_startofpacket_i;
    assign busy = (state_q != IDLE_S);

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_rr_picker (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        src_valid_d = src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_data_d  = src_data_q;
        snk_ready_o = '0;
        drop_inc    = '0;
        out_free    = !src_valid_q || src_ready_i;

        if (out_free) src_valid_d = 1'b0;

        // Stray beats from anyone but the active owner are swallowed in every state.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (snk_valid_i[i] && !snk_startofpacket_i[i] && !(busy && owner_q == IW'(i))) begin
                snk_ready_o[i] = 1'b1;
                drop_inc       = drop_inc + 5'd1;
            end
        end

        unique case (state_q)
            IDLE_S: begin
                if (|pick_gnt) begin
                    owner_d    = pick_idx;
                    rr_ptr_d   = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT_S;
                end
            end
            GRANT_S: begin
                snk_ready_o[owner_q] = out_free;
                if (out_free && snk_valid_i[owner_q]) begin
                    src_valid_d = 1'b1;
                    src_data_d  = snk_data_i[owner_q];
                    src_sop_d   = snk_startofpacket_i[owner_q] && (beat_cnt_q == '0);
                    src_eop_d   = snk_endofpacket_i[owner_q] || (beat_cnt_q == LAST_BEAT);
                    beat_cnt_d  = beat_cnt_q + BW'(1);
                    if (snk_endofpacket_i[owner_q]) state_d = IDLE_S;
                    else if (beat_cnt_q == LAST_BEAT) state_d = DROP_S;
                end
            end
            DROP_S: begin
                snk_ready_o[owner_q] = 1'b1;
                if (snk_valid_i[owner_q]) begin
                    drop_inc = drop_inc + 5'd1;
                    if (snk_endofpacket_i[owner_q]) state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase

        drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE_S;
            owner_q     <= '0;
            rr_ptr_q    <= IW'(NUM_SRC - 1);
            beat_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_data_q  <= src_data_d;
        end
    end

    assign src_data_o          = src_data_q;
    assign src_startofpacket_o = src_sop_q;
    assign src_endofpacket_o   = src_eop_q;
    assign src_valid_o         = src_valid_q;
    assign grant_id_o          = busy ? owner_q : rr_ptr_q;
    assign busy_o              = busy;
    assign drop_cnt_o          = drop_cnt_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// Self-checking bench for sort_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level round-robin reference model.
module tb_sort_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int ML = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic                  clk_i = 1'b0;
    logic                  arst_n_i = 1'b0;
    logic [NS-1:0][DW-1:0] snk_data_i = '0;
    logic [NS-1:0]         snk_startofpacket_i = '0;
    logic [NS-1:0]         snk_endofpacket_i = '0;
    logic [NS-1:0]         snk_valid_i = '0;
    logic [NS-1:0]         snk_ready_o;
    logic [DW-1:0]         src_data_o;
    logic                  src_startofpacket_o;
    logic                  src_endofpacket_o;
    logic                  src_valid_o;
    logic                  src_ready_i = 1'b1;
    logic [IW-1:0]         grant_id_o;
    logic                  busy_o;
    logic [15:0]           drop_cnt_o;

    sort_arbiter #(
        .DWIDTH      (DW),
        .NUM_SRC     (NS),
        .MAX_PKT_LEN (ML)
    ) dut (
        .clk_i               (clk_i),
        .arst_n_i            (arst_n_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .grant_id_o          (grant_id_o),
        .busy_o              (busy_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int    vectors     = 0;
    int    miscompares = 0;

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    int    exp_gnt [$];
    bit    rdy_script [$];
    bit    rdy_rand  = 1'b0;
    int    m_ptr     = NS - 1;
    int    exp_drop  = 0;
    bit    prev_hold = 1'b0;
    bit    prev_busy = 1'b0;
    logic [10:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: whole packets, round-robin over sources with a pending packet.
    task automatic plan();
        beat_t cq [NS][$];
        beat_t b, o;
        int    pick, n;
        for (int i = 0; i < NS; i++) cq[i] = src_q[i];
        for (int guard = 0; guard < 512; guard++) begin
            for (int i = 0; i < NS; i++)
                while (cq[i].size() > 0 && !cq[i][0].sop) begin
                    void'(cq[i].pop_front());
                    exp_drop++;
                end
            pick = -1;
            for (int k = 1; k <= NS; k++)
                if (cq[(m_ptr + k) % NS].size() > 0) begin
                    pick = (m_ptr + k) % NS;
                    break;
                end
            if (pick < 0) break;
            m_ptr = pick;
            exp_gnt.push_back(pick);
            n = 0;
            do begin
                b = cq[pick].pop_front();
                n++;
                if (n <= ML) begin
                    o.data = b.data;
                    o.sop  = (n == 1);
                    o.eop  = b.eop || (n == ML);
                    exp_q.push_back(o);
                end else begin
                    exp_drop++;
                end
            end while (!b.eop && cq[pick].size() > 0);
        end
    endtask

    task automatic push_pkt(input int s, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = DW'(base + i);
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic push_stray(input int s, input int data);
        beat_t b;
        b.data = DW'(data);
        b.sop  = 1'b0;
        b.eop  = 1'b0;
        src_q[s].push_back(b);
    endtask

    task automatic gen_round();
        beat_t b;
        int    np, len;
        for (int s = 0; s < NS; s++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) begin
                    b.data = DW'($urandom);
                    b.sop  = (i == 0) || ($urandom_range(0, 3) == 0);
                    b.eop  = (i == len - 1);
                    src_q[s].push_back(b);
                end
            end
        end
    endtask

    task automatic check_out();
        beat_t       e;
        logic [31:0] exp;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            exp = 32'(e);
        end else begin
            exp = 32'hFFFF_FFFF;
        end
        check("out_beat", 32'({src_data_o, src_startofpacket_o, src_endofpacket_o}), exp);
    endtask

    // One clock: drive at negedge, sample #1 later, pop accepted heads at posedge.
    task automatic step();
        logic [NS-1:0] acc;
        logic [31:0]   eg;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                snk_valid_i[i]         = 1'b1;
                snk_data_i[i]          = src_q[i][0].data;
                snk_startofpacket_i[i] = src_q[i][0].sop;
                snk_endofpacket_i[i]   = src_q[i][0].eop;
            end else begin
                snk_valid_i[i]         = 1'b0;
                snk_data_i[i]          = '0;
                snk_startofpacket_i[i] = 1'b0;
                snk_endofpacket_i[i]   = 1'b0;
            end
        end
        if (rdy_script.size() > 0) src_ready_i = rdy_script.pop_front();
        else if (rdy_rand)         src_ready_i = 1'($urandom_range(0, 1));
        else                       src_ready_i = 1'b1;
        #1;
        if (prev_hold)
            check("hold_stable",
                  32'({src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o}),
                  32'(prev_out));
        if (busy_o && !prev_busy) begin
            eg = (exp_gnt.size() > 0) ? 32'(exp_gnt.pop_front()) : 32'hFFFF_FFFF;
            check("grant_id", 32'(grant_id_o), eg);
        end
        if (src_valid_o && src_ready_i) check_out();
        prev_hold = src_valid_o && !src_ready_i;
        prev_out  = {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o};
        prev_busy = busy_o;
        acc = snk_valid_i & snk_ready_o;
        @(posedge clk_i);
        for (int i = 0; i < NS; i++)
            if (acc[i]) void'(src_q[i].pop_front());
        @(negedge clk_i);
    endtask

    function automatic bit idle_all();
        bit any = 1'b0;
        for (int i = 0; i < NS; i++) any |= (src_q[i].size() > 0);
        return !any && exp_q.size() == 0 && !busy_o && !src_valid_o;
    endfunction

    task automatic drain(input string tag);
        for (int n = 0; n < 3000; n++) begin
            if (idle_all()) break;
            step();
        end
        check({tag, "_done"}, 32'(idle_all()), 32'd1);
        check({tag, "_drop"}, 32'(drop_cnt_o), 32'(exp_drop));
        check({tag, "_grants_left"}, 32'(exp_gnt.size()), 32'd0);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        exp_gnt.delete();
        rdy_script.delete();
        snk_valid_i         = '0;
        snk_startofpacket_i = '0;
        snk_endofpacket_i   = '0;
        snk_data_i          = '0;
        src_ready_i         = 1'b1;
        m_ptr     = NS - 1;
        exp_drop  = 0;
        prev_hold = 1'b0;
        prev_busy = 1'b0;
        rdy_rand  = 1'b0;
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        check("rst_valid", 32'(src_valid_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_gid",   32'(grant_id_o), 32'd3);
        check("rst_drop",  32'(drop_cnt_o), 32'd0);
        check("rst_data",  32'({src_data_o, src_startofpacket_o, src_endofpacket_o}), 32'd0);
        @(negedge clk_i);

        // src0 and src2 race: 0 first, then 2
        push_pkt(0, 3, 8'h10);
        push_pkt(2, 3, 8'h20);
        plan();
        drain("two_src");

        // All four with one-beat packets: order 0,1,2,3,0
        do_reset();
        push_pkt(0, 1, 8'h01);
        push_pkt(0, 1, 8'h05);
        push_pkt(1, 1, 8'h02);
        push_pkt(2, 1, 8'h03);
        push_pkt(3, 1, 8'h04);
        plan();
        drain("rr_order");

        // 10-beat packet truncated to 8, 2 beats discarded
        do_reset();
        push_pkt(1, 10, 1);
        plan();
        drain("truncate");
        check("truncate_drop2", 32'(drop_cnt_o), 32'd2);

        // Back-pressure during a 4-beat packet
        do_reset();
        push_pkt(0, 4, 8'h40);
        plan();
        rdy_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        drain("stall");

        // Stray beats from src3 during src0's packet
        do_reset();
        push_pkt(0, 6, 8'h60);
        for (int k = 0; k < 5; k++) push_stray(3, 8'hE0 + k);
        plan();
        drain("stray");
        check("stray_drop5", 32'(drop_cnt_o), 32'd5);

        // Reset in the middle of a 5-beat packet
        do_reset();
        push_pkt(1, 5, 8'h21);
        plan();
        for (int n = 0; n < 50 && src_q[1].size() > 3; n++) step();
        check("mid_reached", 32'(src_q[1].size()), 32'd3);
        arst_n_i = 1'b0;
        #1;
        check("mid_rst_out", 32'({src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o}), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_gid",  32'(grant_id_o), 32'd3);
        do_reset();
        #1;
        check("post_rst_idle", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        push_pkt(1, 2, 8'h31);
        push_pkt(0, 3, 8'h35);
        plan();
        drain("post_rst");

        // Randomized traffic with random back-pressure
        do_reset();
        for (int r = 0; r < 12; r++) begin
            gen_round();
            plan();
            rdy_rand = 1'b1;
            drain("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
